down_counter_ld: RTL and testbench

- Loadable modulo-2^WIDTH down counter; the count-down counterpart of the team's up counter.
- Supports a free-running wrap mode and a one-shot mode that stops at zero.
- Produces a one-cycle terminal-count pulse and a sticky done flag.
- Used as a reload/timeout timer beside the up counters in the counter library.

---
 rtl/down_counter_ld.sv | 95 +++++++++
 tb/tb_down_counter_ld.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/down_counter_ld.sv
// down_counter_ld
//
// Loadable modulo-2^WIDTH down counter used as a reload/timeout timer in the
// counter library. It has two modes:
//   - wrap mode (mode=0): free-running. The count goes from 0 back to MAX.
//   - one-shot mode (mode=1): the count stops at 0 and raises a sticky done
//     flag. Only a load or a reset releases it.
//
// Ports:
//   clk      - system clock; all state updates on the rising edge
//   reset    - asynchronous, active-high reset (Q=MAX, tc=0, done=0, RUN)
//   en       - count enable; decrement on the rising edge when high
//   load     - synchronous load strobe; takes priority over en
//   load_val - value loaded into Q when load=1
//   mode     - 0 = wrap, 1 = one-shot
//   Q        - current count, registered
//   tc       - terminal-count pulse, registered, one cycle wide
//   done     - one-shot completion flag, registered, sticky

module down_counter_ld #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             done
);

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  state_t state;

  // Controller and datapath in one registered process.
  // Priority on each edge is reset, then load, then the state's own behaviour.
  // A load always returns the counter to RUN with tc and done cleared, so a
  // load that lands on a zero-count edge suppresses the terminal event.
  // tc defaults low on every non-reset edge. It is raised only on the edge
  // that consumes the zero count, which keeps it exactly one cycle wide.
  // In DONE, en and mode are ignored, and Q and done are re-asserted each
  // cycle so the expired state stays pinned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Q     <= MAX;
      tc    <= 1'b0;
      done  <= 1'b0;
      state <= RUN;
    end else if (load) begin
      Q     <= load_val;
      tc    <= 1'b0;
      done  <= 1'b0;
      state <= RUN;
    end else begin
      tc <= 1'b0;
      case (state)
        RUN: begin
          if (en) begin
            if (Q != ZERO) begin
              Q <= Q - ONE;
            end else if (!mode) begin
              Q  <= MAX;
              tc <= 1'b1;
            end else begin
              Q     <= ZERO;
              tc    <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          Q    <= ZERO;
          done <= 1'b1;
        end
        default: begin
          Q     <= MAX;
          done  <= 1'b0;
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_counter_ld.sv
// tb_down_counter_ld
//
// Directed testbench for down_counter_ld with WIDTH=3.
// Inputs are driven 1 ns after each rising edge. Outputs are checked at that
// same point, well away from the next active edge. Expected values are
// written out by hand from the counter's intended behaviour.

module tb_down_counter_ld;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [2:0] load_val;
  logic       mode;
  logic [2:0] Q;
  logic       tc;
  logic       done;

  int assertions;
  int failures;

  down_counter_ld #(.WIDTH(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .Q        (Q),
    .tc       (tc),
    .done     (done)
  );

  // 10 ns clock with rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one set of inputs, then wait for the next rising edge plus 1 ns.
  task automatic applyStimulus(input logic e, input logic l,
                               input logic [2:0] lv, input logic m);
    en       = e;
    load     = l;
    load_val = lv;
    mode     = m;
    @(posedge clk);
    #1;
  endtask

  // Compare all three outputs against the hand-computed expectations.
  task automatic checkOutput(input string tag, input logic [2:0] expQ,
                             input logic expTc, input logic expDone);
    assertions++;
    assert (Q === expQ) else begin
      failures++;
      $error("[TB] FAIL %s Q: got %0d expected %0d", tag, Q, expQ);
    end
    assertions++;
    assert (tc === expTc) else begin
      failures++;
      $error("[TB] FAIL %s tc: got %0b expected %0b", tag, tc, expTc);
    end
    assertions++;
    assert (done === expDone) else begin
      failures++;
      $error("[TB] FAIL %s done: got %0b expected %0b", tag, done, expDone);
    end
  endtask

  // Directed test sequence.
  initial begin
    assertions = 0;
    failures   = 0;
    reset      = 1'b1;
    en         = 1'b0;
    load       = 1'b0;
    load_val   = 3'd0;
    mode       = 1'b0;

    #12;
    checkOutput("reset_state", 3'd7, 1'b0, 1'b0);
    reset = 1'b0;

    // Wrap mode: 7 counts down to 0, wraps to 7 with tc, then continues.
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
      checkOutput("wrap_count", 3'(7 - i), 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("wrap_tc", 3'd7, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("wrap_after", 3'd6, 1'b0, 1'b0);

    // One-shot mode: load 3, count to 0, enter DONE, then stay pinned there.
    applyStimulus(1'b1, 1'b1, 3'd3, 1'b1);
    checkOutput("os_load", 3'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("os_2", 3'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("os_1", 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("os_0", 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("os_enter_done", 3'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("os_done_hold", 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
    checkOutput("os_done_en0", 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("os_done_mode0", 3'd0, 1'b0, 1'b1);

    // A load recovers the counter from DONE back to RUN.
    applyStimulus(1'b1, 1'b1, 3'd6, 1'b1);
    checkOutput("done_recover", 3'd6, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("recover_count", 3'd5, 1'b0, 1'b0);

    // Load coinciding with an enabled zero count: the load wins.
    applyStimulus(1'b0, 1'b1, 3'd0, 1'b1);
    checkOutput("load_zero", 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd6, 1'b1);
    checkOutput("load_priority", 3'd6, 1'b0, 1'b0);

    // Loading 0 in one-shot mode with en=1 enters DONE on the next edge.
    applyStimulus(1'b0, 1'b1, 3'd0, 1'b1);
    checkOutput("load0_os", 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("load0_done", 3'd0, 1'b1, 1'b1);

    // Asynchronous reset while tc and done are both high.
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_done", 3'd7, 1'b0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("post_rst_first", 3'd6, 1'b0, 1'b0);

    // Enable gating: hold 5 for three cycles, then count 4, 3.
    applyStimulus(1'b0, 1'b1, 3'd5, 1'b0);
    checkOutput("gate_load", 3'd5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
      checkOutput("gate_hold", 3'd5, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("gate_4", 3'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("gate_3", 3'd3, 1'b0, 1'b0);

    // Asynchronous reset between edges while Q=2.
    applyStimulus(1'b0, 1'b1, 3'd2, 1'b0);
    checkOutput("rst_mid_load", 3'd2, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_mid", 3'd7, 1'b0, 1'b0);
    reset = 1'b0;

    // Mode switch mid-count: goes 1, 0, 0 into DONE instead of wrapping.
    applyStimulus(1'b0, 1'b1, 3'd2, 1'b0);
    checkOutput("ms_load", 3'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("ms_1", 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("ms_0", 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("ms_done", 3'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("ms_done_hold", 3'd0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertions, failures);
    $finish;
  end

endmodule
